// File: rtl/adder_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : adder_arbiter_if
// Purpose  : Two requester ports and one result port of the shared adder.
// Revision : 1.0  initial release
// ============================================================================
interface adder_arbiter_if;
  logic        req0_valid;
  logic [31:0] req0_a;
  logic [31:0] req0_b;
  logic        req0_cin;
  logic        req0_ready;

  logic        req1_valid;
  logic [31:0] req1_a;
  logic [31:0] req1_b;
  logic        req1_cin;
  logic        req1_ready;

  logic        res_valid;
  logic        res_ready;
  logic        res_id;
  logic [31:0] res_sum;
  logic        res_cout;

  modport master (
    output req0_valid, req0_a, req0_b, req0_cin,
    output req1_valid, req1_a, req1_b, req1_cin,
    output res_ready,
    input  req0_ready, req1_ready,
    input  res_valid, res_id, res_sum, res_cout
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_cin,
    input  req1_valid, req1_a, req1_b, req1_cin,
    input  res_ready,
    output req0_ready, req1_ready,
    output res_valid, res_id, res_sum, res_cout
  );
endinterface
`default_nettype wire

// File: rtl/adder_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : adder_arbiter
// Purpose  : One 32-bit adder shared by two requesters, registered result.
// Revision : 1.0  initial release
// ============================================================================
module adder_arbiter #(
  parameter int FIXED_PRIO = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  adder_arbiter_if.slave  bus
);

  logic        r_res_valid;
  logic        r_res_id;
  logic        r_res_cout;
  logic [31:0] r_res_sum;
  logic        r_ptr;

  logic        w_slot_free;
  logic        w_prefer1;
  logic        w_pick1;
  logic        w_accept;
  logic [31:0] w_a;
  logic [31:0] w_b;
  logic        w_cin;
  logic [32:0] w_total;

  assign w_slot_free = ~r_res_valid | bus.res_ready;

  // In fixed-priority mode the pointer is folded away and requester 0 always wins a tie.
  assign w_prefer1 = (FIXED_PRIO == 0) ? r_ptr : 1'b0;
  assign w_pick1   = bus.req1_valid & (~bus.req0_valid | w_prefer1);

  // rst_n gates the grant so both readies are low while reset is held.
  assign w_accept  = rst_n & w_slot_free & (bus.req0_valid | bus.req1_valid);

  assign bus.req0_ready = w_accept & ~w_pick1;
  assign bus.req1_ready = w_accept &  w_pick1;

  assign w_a     = w_pick1 ? bus.req1_a   : bus.req0_a;
  assign w_b     = w_pick1 ? bus.req1_b   : bus.req0_b;
  assign w_cin   = w_pick1 ? bus.req1_cin : bus.req0_cin;
  assign w_total = {1'b0, w_a} + {1'b0, w_b} + {32'd0, w_cin};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res_valid <= 1'b0;
      r_res_id    <= 1'b0;
      r_res_cout  <= 1'b0;
      r_res_sum   <= 32'd0;
      r_ptr       <= 1'b0;
    end else if (w_accept) begin
      r_res_valid <= 1'b1;
      r_res_id    <= w_pick1;
      r_res_cout  <= w_total[32];
      r_res_sum   <= w_total[31:0];
      r_ptr       <= ~w_pick1;
    end else if (w_slot_free) begin
      r_res_valid <= 1'b0;
    end
  end

  assign bus.res_valid = r_res_valid;
  assign bus.res_id    = r_res_id;
  assign bus.res_cout  = r_res_cout;
  assign bus.res_sum   = r_res_sum;

endmodule
`default_nettype wire

// File: tb/tb_adder_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_adder_arbiter
// Purpose  : Self-checking bench for round-robin and fixed-priority instances.
// Revision : 1.0  initial release
// ============================================================================
module tb_adder_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  adder_arbiter_if bus_rr();
  adder_arbiter_if bus_fp();

  adder_arbiter #(.FIXED_PRIO(0)) u_rr (.clk(clk), .rst_n(rst_n), .bus(bus_rr.slave));
  adder_arbiter #(.FIXED_PRIO(1)) u_fp (.clk(clk), .rst_n(rst_n), .bus(bus_fp.slave));

  int checks = 0;
  int passed = 0;

  // Both instances always see identical stimulus.
  task automatic drive(input logic v0, input logic [31:0] a0, input logic [31:0] b0, input logic c0,
                       input logic v1, input logic [31:0] a1, input logic [31:0] b1, input logic c1,
                       input logic rr);
    bus_rr.req0_valid = v0; bus_rr.req0_a = a0; bus_rr.req0_b = b0; bus_rr.req0_cin = c0;
    bus_rr.req1_valid = v1; bus_rr.req1_a = a1; bus_rr.req1_b = b1; bus_rr.req1_cin = c1;
    bus_rr.res_ready  = rr;
    bus_fp.req0_valid = v0; bus_fp.req0_a = a0; bus_fp.req0_b = b0; bus_fp.req0_cin = c0;
    bus_fp.req1_valid = v1; bus_fp.req1_a = a1; bus_fp.req1_b = b1; bus_fp.req1_cin = c1;
    bus_fp.res_ready  = rr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic logic [32:0] add33(input logic [31:0] a, input logic [31:0] b, input logic c);
    longint unsigned s;
    s = longint'(a) + longint'(b) + longint'(c);
    return s[32:0];
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1, 32'h1234, 32'h5678, 1, 1, 32'h9, 32'h7, 1, 1);
    @(posedge clk);
    #1;
    checks++; if (bus_rr.req0_ready !== 1'b0 || bus_rr.req1_ready !== 1'b0)
      $display("FAIL reset_ready_rr got %b%b want 00", bus_rr.req0_ready, bus_rr.req1_ready); else passed++;
    checks++; if (bus_fp.req0_ready !== 1'b0 || bus_fp.req1_ready !== 1'b0)
      $display("FAIL reset_ready_fp got %b%b want 00", bus_fp.req0_ready, bus_fp.req1_ready); else passed++;
    checks++; if (bus_rr.res_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", bus_rr.res_valid); else passed++;
    checks++; if (bus_rr.res_sum !== 32'd0 || bus_rr.res_cout !== 1'b0 || bus_rr.res_id !== 1'b0)
      $display("FAIL reset_result got sum=%h cout=%b id=%b want 0", bus_rr.res_sum, bus_rr.res_cout, bus_rr.res_id); else passed++;
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    drive(1, 32'h0040_0000, 32'd4, 0, 0, 32'hDEAD_BEEF, 32'hFFFF_0000, 1, 1);
    #1;
    checks++; if (bus_rr.req0_ready !== 1'b1 || bus_rr.req1_ready !== 1'b0)
      $display("FAIL single_ready got %b%b want 10", bus_rr.req0_ready, bus_rr.req1_ready); else passed++;
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    #1;
    checks++; if (bus_rr.res_valid !== 1'b1 || bus_rr.res_sum !== 32'h0040_0004 || bus_rr.res_cout !== 1'b0 || bus_rr.res_id !== 1'b0)
      $display("FAIL single_result got v=%b sum=%h cout=%b id=%b want v=1 sum=00400004 cout=0 id=0",
               bus_rr.res_valid, bus_rr.res_sum, bus_rr.res_cout, bus_rr.res_id); else passed++;
    tick();
    checks++; if (bus_rr.res_valid !== 1'b0) $display("FAIL idle_clear got %b want 0", bus_rr.res_valid); else passed++;
  endtask

  task automatic test_wrap();
    do_reset();
    drive(0, 32'h5555_5555, 32'h1, 1, 1, 32'hFFFF_FFFF, 32'h1, 0, 1);
    #1;
    checks++; if (bus_rr.req1_ready !== 1'b1 || bus_rr.req0_ready !== 1'b0)
      $display("FAIL wrap_ready got %b%b want 01", bus_rr.req0_ready, bus_rr.req1_ready); else passed++;
    tick();
    drive(0, 0, 0, 0, 1, 32'h7FFF_FFFF, 32'h0, 1, 1);
    #1;
    checks++; if (bus_rr.res_sum !== 32'h0 || bus_rr.res_cout !== 1'b1 || bus_rr.res_id !== 1'b1)
      $display("FAIL wrap_carry got sum=%h cout=%b id=%b want 00000000/1/1", bus_rr.res_sum, bus_rr.res_cout, bus_rr.res_id); else passed++;
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    #1;
    checks++; if (bus_rr.res_valid !== 1'b1 || bus_rr.res_sum !== 32'h8000_0000 || bus_rr.res_cout !== 1'b0)
      $display("FAIL wrap_cin got v=%b sum=%h cout=%b want 1/80000000/0", bus_rr.res_valid, bus_rr.res_sum, bus_rr.res_cout); else passed++;
    tick();
  endtask

  task automatic test_contention();
    logic [32:0] exp_t;
    logic        exp_r0;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      if (i < 4) drive(1, 32'h100 + i, i, 0, 1, 32'h2000 + i, 32'h10, 1, 1);
      else       drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
      #1;
      if (i < 4) begin
        exp_r0 = (i % 2 == 0);
        checks++; if (bus_rr.req0_ready !== exp_r0 || bus_rr.req1_ready !== ~exp_r0)
          $display("FAIL contention_grant cycle %0d got %b%b want %b%b", i, bus_rr.req0_ready, bus_rr.req1_ready, exp_r0, ~exp_r0); else passed++;
      end
      if (i > 0) begin
        exp_t = ((i - 1) % 2 == 0) ? add33(32'h100 + (i - 1), i - 1, 0) : add33(32'h2000 + (i - 1), 32'h10, 1);
        checks++; if (bus_rr.res_valid !== 1'b1 || bus_rr.res_id !== 1'((i - 1) % 2) || bus_rr.res_sum !== exp_t[31:0])
          $display("FAIL contention_result cycle %0d got v=%b id=%b sum=%h want v=1 id=%0d sum=%h",
                   i, bus_rr.res_valid, bus_rr.res_id, bus_rr.res_sum, (i - 1) % 2, exp_t[31:0]); else passed++;
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [32:0] exp_t;
    do_reset();
    drive(1, 32'hAAAA_0000, 32'h1111, 0, 1, 32'h3, 32'h4, 0, 1);
    tick();
    exp_t = add33(32'hAAAA_0000, 32'h1111, 0);
    for (int i = 0; i < 3; i++) begin
      drive(1, $urandom, $urandom, 1'($urandom), 1, $urandom, $urandom, 1'($urandom), 0);
      #1;
      checks++; if (bus_rr.req0_ready !== 1'b0 || bus_rr.req1_ready !== 1'b0)
        $display("FAIL stall_ready cycle %0d got %b%b want 00", i, bus_rr.req0_ready, bus_rr.req1_ready); else passed++;
      checks++; if (bus_rr.res_valid !== 1'b1 || bus_rr.res_sum !== exp_t[31:0] || bus_rr.res_id !== 1'b0 || bus_rr.res_cout !== exp_t[32])
        $display("FAIL stall_hold cycle %0d got v=%b sum=%h id=%b want v=1 sum=%h id=0",
                 i, bus_rr.res_valid, bus_rr.res_sum, bus_rr.res_id, exp_t[31:0]); else passed++;
      tick();
    end
    drive(1, 32'h1, 32'h1, 0, 1, 32'h0BAD_0000, 32'h0000_F00D, 1, 1);
    #1;
    checks++; if (bus_rr.req0_ready !== 1'b0 || bus_rr.req1_ready !== 1'b1)
      $display("FAIL drain_grant got %b%b want 01", bus_rr.req0_ready, bus_rr.req1_ready); else passed++;
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    #1;
    checks++; if (bus_rr.res_valid !== 1'b1 || bus_rr.res_id !== 1'b1 || bus_rr.res_sum !== 32'h0BAD_F00E)
      $display("FAIL drain_result got v=%b id=%b sum=%h want 1/1/0badf00e", bus_rr.res_valid, bus_rr.res_id, bus_rr.res_sum); else passed++;
    tick();
  endtask

  task automatic test_fixed_prio();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h40 * i, 32'h4, 0, 1, 32'h9999, 32'h1, 0, 1);
      #1;
      checks++; if (bus_fp.req0_ready !== 1'b1 || bus_fp.req1_ready !== 1'b0)
        $display("FAIL fixed_grant cycle %0d got %b%b want 10", i, bus_fp.req0_ready, bus_fp.req1_ready); else passed++;
      if (i > 0) begin
        checks++; if (bus_fp.res_id !== 1'b0 || bus_fp.res_sum !== 32'h40 * (i - 1) + 32'h4)
          $display("FAIL fixed_result cycle %0d got id=%b sum=%h want id=0 sum=%h", i, bus_fp.res_id, bus_fp.res_sum, 32'h40 * (i - 1) + 32'h4); else passed++;
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(1, 32'h77, 32'h1, 0, 0, 0, 0, 0, 1);
    tick();
    drive(1, 32'h55, 32'h5, 1, 1, 32'h66, 32'h6, 1, 1);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus_rr.res_valid !== 1'b0 || bus_rr.res_sum !== 32'd0 || bus_rr.res_cout !== 1'b0 || bus_rr.res_id !== 1'b0)
      $display("FAIL midreset_outputs got v=%b sum=%h cout=%b id=%b want all 0", bus_rr.res_valid, bus_rr.res_sum, bus_rr.res_cout, bus_rr.res_id); else passed++;
    checks++; if (bus_rr.req0_ready !== 1'b0 || bus_rr.req1_ready !== 1'b0)
      $display("FAIL midreset_ready got %b%b want 00", bus_rr.req0_ready, bus_rr.req1_ready); else passed++;
    tick();
    rst_n = 1'b1;
    #1;
    checks++; if (bus_rr.req0_ready !== 1'b1 || bus_rr.req1_ready !== 1'b0)
      $display("FAIL post_reset_grant got %b%b want 10", bus_rr.req0_ready, bus_rr.req1_ready); else passed++;
    tick();
    checks++; if (bus_rr.res_valid !== 1'b1 || bus_rr.res_id !== 1'b0 || bus_rr.res_sum !== 32'h5B)
      $display("FAIL post_reset_result got v=%b id=%b sum=%h want 1/0/0000005b", bus_rr.res_valid, bus_rr.res_id, bus_rr.res_sum); else passed++;
  endtask

  // Reference: whoever was served last yields a tie (RR); requester 0 always wins a tie (fixed).
  task automatic test_random();
    logic        m_valid [2];
    logic        m_id    [2];
    logic        m_last  [2];
    logic [32:0] m_total [2];
    logic        v0, v1, c0, c1, rr, free;
    logic [31:0] a0, b0, a1, b1;
    logic        o_r0, o_r1, o_v, o_id, o_c;
    logic [31:0] o_s;
    int          w;
    do_reset();
    for (int k = 0; k < 2; k++) begin
      m_valid[k] = 0; m_id[k] = 0; m_last[k] = 1; m_total[k] = '0;
    end
    for (int n = 0; n < 300; n++) begin
      v0 = ($urandom_range(0, 9) < 6); v1 = ($urandom_range(0, 9) < 6);
      rr = ($urandom_range(0, 9) < 7);
      a0 = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom; b0 = $urandom; c0 = 1'($urandom);
      a1 = $urandom; b1 = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom; c1 = 1'($urandom);
      drive(v0, a0, b0, c0, v1, a1, b1, c1, rr);
      #1;
      for (int k = 0; k < 2; k++) begin
        if (k == 0) begin
          o_r0 = bus_rr.req0_ready; o_r1 = bus_rr.req1_ready; o_v = bus_rr.res_valid;
          o_id = bus_rr.res_id; o_s = bus_rr.res_sum; o_c = bus_rr.res_cout;
        end else begin
          o_r0 = bus_fp.req0_ready; o_r1 = bus_fp.req1_ready; o_v = bus_fp.res_valid;
          o_id = bus_fp.res_id; o_s = bus_fp.res_sum; o_c = bus_fp.res_cout;
        end
        free = !m_valid[k] || rr;
        if (!free || (!v0 && !v1)) w = -1;
        else if (v0 && !v1)        w = 0;
        else if (!v0 && v1)        w = 1;
        else if (k == 1)           w = 0;
        else                       w = m_last[k] ? 0 : 1;
        checks++; if (o_r0 !== (w == 0) || o_r1 !== (w == 1))
          $display("FAIL rand_ready dut%0d cycle %0d got %b%b want %b%b", k, n, o_r0, o_r1, w == 0, w == 1); else passed++;
        checks++; if (o_v !== m_valid[k])
          $display("FAIL rand_valid dut%0d cycle %0d got %b want %b", k, n, o_v, m_valid[k]); else passed++;
        if (m_valid[k]) begin
          checks++; if (o_s !== m_total[k][31:0] || o_c !== m_total[k][32] || o_id !== m_id[k])
            $display("FAIL rand_result dut%0d cycle %0d got sum=%h cout=%b id=%b want sum=%h cout=%b id=%b",
                     k, n, o_s, o_c, o_id, m_total[k][31:0], m_total[k][32], m_id[k]); else passed++;
        end
        if (w >= 0) begin
          m_valid[k] = 1;
          m_id[k]    = (w == 1);
          m_last[k]  = (w == 1);
          m_total[k] = (w == 0) ? add33(a0, b0, c0) : add33(a1, b1, c1);
        end else if (free) begin
          m_valid[k] = 0;
        end
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_contention();
    test_backpressure();
    test_fixed_prio();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/adder_arbiter.md
ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 Parameter: FIXED_PRIO, default 0, 0 = round-robin arbitration, 1 = requester 0 always wins.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req0_valid  input  1  requester 0 (PC-increment path) has an add pending.
REQ-005 req0_a, req0_b  input  32 each  requester 0 operands.
REQ-006 req0_cin  input  1  requester 0 carry-in.
REQ-007 req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-008 req1_valid, req1_a, req1_b, req1_cin, req1_ready  same widths and directions as requester 0, for requester 1 (branch-target/ALU path).
REQ-009 res_valid  output  1  result register holds a valid result.
REQ-010 res_ready  input  1  consumer accepts the result this cycle.
REQ-011 res_id  output  1  requester index that owns the result.
REQ-012 res_sum  output  32  registered sum.
REQ-013 res_cout  output  1  registered carry-out (bit 32 of the sum).

Function
REQ-014 The block SHALL contain one shared 32-bit adder computing {cout,sum} = a + b + cin on the granted requester's operands; sum is modulo 2^32.
REQ-015 Slot free = !res_valid | res_ready; acceptance SHALL occur only when the slot is free.
REQ-016 Grant SHALL be combinational: reqX_ready = slot free & reqX_valid & requester X wins arbitration; at most one ready is high per cycle.
REQ-017 With only one requester valid, that requester SHALL win.
REQ-018 With both valid and FIXED_PRIO=0, the winner SHALL be the requester indicated by a 1-bit pointer; after any accepted grant, the pointer SHALL switch to the other requester.
REQ-019 With FIXED_PRIO=1, requester 0 SHALL win whenever req0_valid is high; the pointer is unused.
REQ-020 The pointer SHALL not change in cycles without an accepted grant.
REQ-021 On acceptance in cycle N: res_valid=1, res_sum, res_cout and res_id = winner index SHALL be registered at the end of cycle N; the result is visible in cycle N+1 (latency 1).
REQ-022 Throughput SHALL be one operation per cycle when res_ready is held high.
REQ-023 If the slot is free and no grant occurs, res_valid SHALL clear at the next edge.
REQ-024 While res_valid=1 and res_ready=0, res_sum, res_cout and res_id SHALL be held stable, and both ready outputs SHALL be 0.
REQ-025 Simultaneous drain and accept (res_valid & res_ready & grant) SHALL replace the result with no bubble cycle.
REQ-026 A requester may drop valid before being granted; the block SHALL retain no state for it.
REQ-027 Operand and carry-in values of a non-granted requester SHALL have no effect on the outputs.

Reset
REQ-028 While rst_n=0: res_valid=0, res_sum=0, res_cout=0, res_id=0, pointer=0 (requester 0 preferred), req0_ready=req1_ready=0, asynchronously.
REQ-029 Assertion of rst_n mid-operation SHALL discard any pending result; the first grant after release SHALL follow pointer=0.

Verification
REQ-030 Single request: req0 a=0x00400000, b=4, cin=0, res_ready=1 -> req0_ready=1 in the same cycle; next cycle res_valid=1, res_sum=0x00400004, res_cout=0, res_id=0.
REQ-031 Wrap: req1 a=0xFFFFFFFF, b=0x00000001, cin=0 -> res_sum=0x00000000, res_cout=1, res_id=1; a=0x7FFFFFFF, b=0, cin=1 -> res_sum=0x80000000, res_cout=0.
REQ-032 Contention, FIXED_PRIO=0: both valid continuously for 4 cycles, res_ready=1 -> grants 0,1,0,1; res_id sequence 0,1,0,1 one cycle later; no idle cycles.
REQ-033 Backpressure: result pending, res_ready=0 for 3 cycles with both requesters valid -> both ready outputs 0 and result stable for all 3 cycles; res_ready=1 -> drain and the next grant occur in the same cycle.
REQ-034 FIXED_PRIO=1: both valid for 3 cycles -> requester 0 granted every cycle, req1_ready stays 0.
REQ-035 Reset mid-operation: res_valid=1 with pointer=1, then rst_n pulsed low -> res_valid=0 and all outputs 0 immediately; after release, both valid -> requester 0 granted first.
